multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle main control unit for the 16-bit RISC core. It fetches each instruction through a valid handshake, holds it in an instruction register (IR), and sequences it through fetch/decode/execute/memory/writeback. It produces the 3-bit `alu_op` that the downstream ALU control stage consumes, plus all datapath strobes. It also keeps a retired-instruction counter.

## Interface
- `OPW`, 4, opcode width (IR[15:12])
- `ALUOP_W`, 3, width of `alu_op`
- `CNT_W`, 16, width of `instret`

- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `imem_valid` in 1, instruction word on `imem_rdata` is valid
- `imem_rdata` in 16, instruction word
- `dmem_ready` in 1, data memory has completed the current access
- `alu_zero` in 1, ALU zero flag, used by BEQ
- `imem_req` out 1, fetch request
- `ir` out 16, instruction register
- `alu_op` out ALUOP_W, operation code to the ALU control stage
- `alu_src` out 1, selects the B operand: 0 = register, 1 = sign-extended IR[5:0]
- `pc_inc` out 1, PC += 1
- `pc_write` out 1, load PC from the target selected by `pc_src`
- `pc_src` out 1, PC target select: 0 = branch target, 1 = jump target
- `mem_read`, `mem_write` out 1 each, data memory strobes
- `mem_to_reg` out 1, writeback data select: 1 = memory, 0 = ALU
- `reg_write` out 1, register file write enable
- `retire` out 1, one-cycle pulse when an instruction completes
- `illegal` out 1, one-cycle pulse on an illegal opcode
- `halted` out 1, the FSM is in the HALT state
- `instret` out CNT_W, retired-instruction count
- `state` out 3, current FSM state

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5. Encodings 6 and 7 return to FETCH on the next edge.
- Opcode decode (IR[15:12]):
  - 0000–0111: R-type; `alu_op` = opcode[2:0]. Encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SLT 111.
  - 1000 ADDI: `alu_op`=000, `alu_src`=1.
  - 1001 LW and 1010 SW: `alu_op`=000, `alu_src`=1.
  - 1011 BEQ: `alu_op`=001.
  - 1100 JMP.
  - 1101 NOP.
  - 1110 HALT.
  - 1111: illegal, executed as NOP.
  - `alu_op` for JMP, NOP, HALT and illegal is 000.
- `alu_op` and `alu_src` are combinational functions of IR only. They are stable from DECODE through the end of the instruction.
- All other strobes are Moore outputs (functions of state and IR only), except `pc_inc`, `pc_write` and `dmem`-gated transitions as stated below.
- State transitions:
  - FETCH: `imem_req`=1. When `imem_valid`=1: `pc_inc`=1 that cycle, IR ← `imem_rdata` at the edge, next state DECODE. Otherwise remain in FETCH.
  - DECODE: always → EXECUTE.
  - EXECUTE, by opcode:
    - R-type and ADDI → WRITEBACK.
    - LW and SW → MEMORY.
    - BEQ: `pc_write` = `alu_zero`, `pc_src`=0, → FETCH.
    - JMP: `pc_write`=1, `pc_src`=1, → FETCH.
    - NOP and illegal → FETCH; illegal also pulses `illegal`.
    - HALT → HALT.
  - MEMORY:
    - LW holds `mem_read`=1 and SW holds `mem_write`=1 until `dmem_ready`=1.
    - On that cycle, LW → WRITEBACK and SW → FETCH.
  - WRITEBACK: `reg_write`=1; `mem_to_reg`=1 for LW. → FETCH.
  - HALT: `halted`=1. Remains in HALT until reset; `imem_valid` is ignored.
- `retire` pulses in the final cycle of each instruction:
  - WRITEBACK;
  - MEMORY for SW, on the `dmem_ready` cycle;
  - EXECUTE for BEQ, JMP, NOP, illegal and HALT.
- `instret` increments on each `retire` and wraps from 0xFFFF to 0x0000.

## Timing
- Reset (async assert, sync release):
  - state=FETCH, IR=16'hD000 (NOP), `instret`=0.
  - Hence `imem_req`=1, `alu_op`=000, and every other output is 0.
- Minimum latency (cycles, with `imem_valid` and `dmem_ready` already high):
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, JMP, NOP, illegal, HALT: 3.
- Each wait cycle on `imem_valid` or `dmem_ready` adds exactly 1 cycle.
- `imem_valid` outside FETCH and `dmem_ready` outside MEMORY are ignored.
- `alu_zero` is sampled only in EXECUTE for BEQ.
- Reset asserted mid-MEMORY drops `mem_read`/`mem_write` immediately (asynchronously). The interrupted instruction is not counted.
- IR changes only at a FETCH accept edge.

## Test plan
- Reset, then `imem_valid`=1 with 16'h0123 (ADD) → states 0,1,2,4,0; `alu_op`=000 from DECODE; `reg_write`=1 in cycle 4; `instret`=1.
- LW 16'h9045 with `dmem_ready` low for 3 cycles → `mem_read` high for 4 cycles; WRITEBACK with `mem_to_reg`=1; total 8 cycles.
- BEQ 16'hB0FF with `alu_zero`=1, then again with `alu_zero`=0 → `pc_write`=1/`pc_src`=0 in EXECUTE the first time; `pc_write`=0 the second time; `alu_op`=001 both times.
- Opcode 1111 → `illegal` pulses once in EXECUTE; `retire`=1; no other strobe asserted.
- HALT 16'hE000, then `imem_valid` held high → `halted`=1 persists and `imem_req`=0. Assert `rst_n`=0 → state=FETCH and `instret`=0.
- Preload `instret`=0xFFFF by issuing 65535 NOPs, then one more NOP → `instret`=0x0000.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control unit of the 16-bit multicycle RISC core. It fetches one
//   instruction word into the IR, steps it through
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK (or HALT), and drives the datapath
//   strobes. It also counts retired instructions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_valid/rdata    instruction word offered to the fetch stage
//   dmem_ready          data memory completed the current access
//   alu_zero            ALU zero flag, used by BEQ only
//   imem_req            fetch request (high in FETCH)
//   ir                  instruction register
//   alu_op, alu_src     ALU operation and B-operand select (decoded from IR)
//   pc_inc, pc_write    PC += 1 / load PC from the target picked by pc_src
//   pc_src              0 = branch target, 1 = jump target
//   mem_read/mem_write  data memory strobes
//   mem_to_reg          writeback select (1 = memory data)
//   reg_write           register file write enable
//   retire, illegal     one-cycle pulses on completion / illegal opcode
//   halted              FSM sits in HALT
//   instret             retired-instruction counter (wraps)
//   state               current FSM state, exported for observation
//
// Handshakes: a fetch completes in any FETCH cycle where imem_valid is high
// (imem_req is the request, imem_valid acts as the ready/accept); a data
// access completes in the MEMORY cycle where dmem_ready is high, the strobe
// being held until then. Both inputs are ignored in every other state.
module multicycle_control_fsm #(
   parameter int OPW     = 4,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               imem_valid,
   input  logic [15:0]        imem_rdata,
   input  logic               dmem_ready,
   input  logic               alu_zero,
   output logic               imem_req,
   output logic [15:0]        ir,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src,
   output logic               pc_inc,
   output logic               pc_write,
   output logic               pc_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               retire,
   output logic               illegal,
   output logic               halted,
   output logic [CNT_W-1:0]   instret,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      ir_q;
   logic [CNT_W-1:0] instret_q;
   logic [OPW-1:0]   opcode;

   logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_ill;

   assign opcode   = ir_q[15 -: OPW];
   assign is_rtype = (opcode[OPW-1] == 1'b0);
   assign is_addi  = (opcode == OPW'(8));
   assign is_lw    = (opcode == OPW'(9));
   assign is_sw    = (opcode == OPW'(10));
   assign is_beq   = (opcode == OPW'(11));
   assign is_jmp   = (opcode == OPW'(12));
   assign is_halt  = (opcode == OPW'(14));
   assign is_ill   = (opcode == OPW'(15));

   // ALU controls depend on IR only, so they hold steady from DECODE until
   // the next fetch accept.
   always_comb begin
      alu_op = '0;
      if (is_rtype)
         alu_op = ALUOP_W'(opcode[2:0]);
      else if (is_beq)
         alu_op = ALUOP_W'(1);
   end

   assign alu_src = is_addi | is_lw | is_sw;

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      pc_inc     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (is_rtype || is_addi) begin
               state_d = S_WRITEBACK;
            end else if (is_lw || is_sw) begin
               state_d = S_MEMORY;
            end else if (is_halt) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               // BEQ, JMP, NOP and illegal all finish here.
               retire   = 1'b1;
               pc_write = is_jmp | (is_beq & alu_zero);
               pc_src   = is_jmp;
               illegal  = is_ill;
               state_d  = S_FETCH;
            end
         end
         S_MEMORY: begin
            mem_read  = is_lw;
            mem_write = is_sw;
            if (dmem_ready) begin
               if (is_lw) begin
                  state_d = S_WRITEBACK;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = is_lw;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_FETCH;  // unused encodings recover to FETCH
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ir_q      <= 16'hD000;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH && imem_valid)
            ir_q <= imem_rdata;
         if (retire)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign ir      = ir_q;
   assign instret = instret_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   // Counter is built narrow so the wrap can be reached in a short run.
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_valid;
   logic [15:0]   imem_rdata;
   logic          dmem_ready;
   logic          alu_zero;
   logic          imem_req;
   logic [15:0]   ir;
   logic [2:0]    alu_op;
   logic          alu_src, pc_inc, pc_write, pc_src, mem_read, mem_write;
   logic          mem_to_reg, reg_write, retire, illegal, halted;
   logic [CW-1:0] instret;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] exp_cnt;
   logic [CW-1:0] exp_q[$];

   multicycle_control_fsm #(.OPW(4), .ALUOP_W(3), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req), .ir(ir),
      .alu_op(alu_op), .alu_src(alu_src), .pc_inc(pc_inc), .pc_write(pc_write),
      .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
      .illegal(illegal), .halted(halted), .instret(instret), .state(state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 16'h0000;
      dmem_ready = 1'b0;
      alu_zero   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = '0;
      exp_q.delete();
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Per-instruction summary: cycle count and how many cycles each strobe was high.
   typedef struct {
      int         cycles;
      int         imem_req;
      int         pc_inc;
      int         mem_rd;
      int         mem_wr;
      int         reg_wr;
      int         m2r;
      int         pc_wr;
      int         pc_src;
      int         ill;
      logic [2:0] alu_op;
      logic       alu_src;
   } sum_t;

   // Reference model: what one instruction should look like, from the
   // instruction set rules (latency, waits, which strobes fire and how long).
   function automatic sum_t model(input logic [15:0] instr, input int iw, input int dw,
                                  input logic zero);
      sum_t e;
      logic [3:0] op;
      bit rt, addi, lw, sw, beq, jmp;
      op   = instr[15:12];
      rt   = (op < 4'd8);
      addi = (op == 4'd8);
      lw   = (op == 4'd9);
      sw   = (op == 4'd10);
      beq  = (op == 4'd11);
      jmp  = (op == 4'd12);
      e.cycles   = iw + ((rt || addi) ? 4 : lw ? 5 + dw : sw ? 4 + dw : 3);
      e.imem_req = iw + 1;
      e.pc_inc   = 1;
      e.mem_rd   = lw ? dw + 1 : 0;
      e.mem_wr   = sw ? dw + 1 : 0;
      e.reg_wr   = (rt || addi || lw) ? 1 : 0;
      e.m2r      = lw ? 1 : 0;
      e.pc_wr    = (jmp || (beq && zero)) ? 1 : 0;
      e.pc_src   = jmp ? 1 : 0;
      e.ill      = (op == 4'd15) ? 1 : 0;
      e.alu_op   = rt ? op[2:0] : beq ? 3'd1 : 3'd0;
      e.alu_src  = addi || lw || sw;
      return e;
   endfunction

   // ---------------- driver ----------------
   // Starts 1 time unit after a rising edge with the DUT in FETCH. Offers the
   // word after iw idle cycles, answers the data access after dw wait cycles,
   // and observes until the retire pulse.
   logic [2:0] trace[8];

   task automatic run_instr(input logic [15:0] instr, input int iw, input int dw,
                            input logic zero, output sum_t o, output bit done);
      int k = 0;
      int mem_seen = 0;
      o = '{cycles: 0, imem_req: 0, pc_inc: 0, mem_rd: 0, mem_wr: 0, reg_wr: 0,
            m2r: 0, pc_wr: 0, pc_src: 0, ill: 0, alu_op: 3'd0, alu_src: 1'b0};
      done = 1'b0;
      while (!done && k < 60) begin
         imem_valid = (k >= iw);
         imem_rdata = instr;
         alu_zero   = zero;
         dmem_ready = (state == 3'd3) ? (mem_seen >= dw) : 1'($urandom_range(0, 1));
         #1;
         if (k < 8) trace[k] = state;
         k++;
         if (state == 3'd3) mem_seen++;
         if (state == 3'd1) begin
            o.alu_op  = alu_op;
            o.alu_src = alu_src;
         end
         o.imem_req += int'(imem_req);
         o.pc_inc   += int'(pc_inc);
         o.mem_rd   += int'(mem_read);
         o.mem_wr   += int'(mem_write);
         o.reg_wr   += int'(reg_write);
         o.m2r      += int'(mem_to_reg);
         o.pc_wr    += int'(pc_write);
         o.pc_src   += int'(pc_src);
         o.ill      += int'(illegal);
         if (retire) done = 1'b1;
         @(posedge clk);
         #1;
      end
      o.cycles   = k;
      imem_valid = 1'b0;
   endtask

   // Run one instruction, then check retire happened and instret advanced.
   task automatic exec(input string tag, input logic [15:0] instr, input int iw,
                       input int dw, input logic zero, output sum_t o);
      bit done;
      run_instr(instr, iw, dw, zero, o, done);
      check({tag, ".retire_seen"}, 32'(done), 32'd1);
      exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back(exp_cnt);
      check({tag, ".instret"}, 32'(instret), 32'(exp_q.pop_front()));
   endtask

   task automatic cmp_all(input string tag, input sum_t a, input sum_t e);
      check({tag, ".cycles"},   a.cycles,   e.cycles);
      check({tag, ".imem_req"}, a.imem_req, e.imem_req);
      check({tag, ".pc_inc"},   a.pc_inc,   e.pc_inc);
      check({tag, ".mem_read"}, a.mem_rd,   e.mem_rd);
      check({tag, ".mem_write"},a.mem_wr,   e.mem_wr);
      check({tag, ".reg_write"},a.reg_wr,   e.reg_wr);
      check({tag, ".mem_to_reg"},a.m2r,     e.m2r);
      check({tag, ".pc_write"}, a.pc_wr,    e.pc_wr);
      check({tag, ".pc_src"},   a.pc_src,   e.pc_src);
      check({tag, ".illegal"},  a.ill,      e.ill);
      check({tag, ".alu_op"},   32'(a.alu_op),  32'(e.alu_op));
      check({tag, ".alu_src"},  32'(a.alu_src), 32'(e.alu_src));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [15:0] instr;
      int          iw;
      int          dw;
      logic        zero;
      int          cycles;
      logic [2:0]  alu_op;
      int          mem_rd;
      int          reg_wr;
      int          pc_wr;
      int          ill;
   } vec_t;

   vec_t vecs[11];

   initial begin
      sum_t o, e;
      bit   done;
      int   guard;
      logic [3:0] op;
      logic [15:0] instr;

      vecs[0]  = '{16'h0123, 0, 0, 1'b0, 4, 3'd0, 0, 1, 0, 0};  // ADD
      vecs[1]  = '{16'h9045, 0, 3, 1'b0, 8, 3'd0, 4, 1, 0, 0};  // LW, 3 wait cycles
      vecs[2]  = '{16'hB0FF, 0, 0, 1'b1, 3, 3'd1, 0, 0, 1, 0};  // BEQ taken
      vecs[3]  = '{16'hB0FF, 0, 0, 1'b0, 3, 3'd1, 0, 0, 0, 0};  // BEQ not taken
      vecs[4]  = '{16'hF000, 0, 0, 1'b0, 3, 3'd0, 0, 0, 0, 1};  // illegal
      vecs[5]  = '{16'hA123, 2, 1, 1'b0, 7, 3'd0, 0, 0, 0, 0};  // SW, fetch+mem waits
      vecs[6]  = '{16'hC000, 1, 0, 1'b1, 4, 3'd0, 0, 0, 1, 0};  // JMP
      vecs[7]  = '{16'h8ABC, 0, 0, 1'b0, 4, 3'd0, 0, 1, 0, 0};  // ADDI
      vecs[8]  = '{16'h5012, 0, 0, 1'b0, 4, 3'd5, 0, 1, 0, 0};  // SLL
      vecs[9]  = '{16'h7000, 3, 0, 1'b0, 7, 3'd7, 0, 1, 0, 0};  // SLT, 3 fetch waits
      vecs[10] = '{16'hD000, 0, 0, 1'b1, 3, 3'd0, 0, 0, 0, 0};  // NOP

      do_reset();

      // Reset values (sampled away from the edge, DUT idle in FETCH).
      check("rst.state",    32'(state),   32'd0);
      check("rst.ir",       32'(ir),      32'hD000);
      check("rst.instret",  32'(instret), 32'd0);
      check("rst.imem_req", 32'(imem_req), 32'd1);
      check("rst.alu_op",   32'(alu_op),  32'd0);
      check("rst.others",   32'({alu_src, pc_inc, pc_write, pc_src, mem_read, mem_write,
                                 mem_to_reg, reg_write, retire, illegal, halted}), 32'd0);

      // ADD right after reset: state walk 0,1,2,4 then back to 0.
      exec("add", 16'h0123, 0, 0, 1'b0, o);
      check("add.trace0", 32'(trace[0]), 32'd0);
      check("add.trace1", 32'(trace[1]), 32'd1);
      check("add.trace2", 32'(trace[2]), 32'd2);
      check("add.trace3", 32'(trace[3]), 32'd4);
      check("add.after",  32'(state),    32'd0);
      check("add.cycles", o.cycles, 4);
      check("add.reg_write", o.reg_wr, 1);
      check("add.ir",     32'(ir), 32'h0123);

      // Table-driven vectors.
      for (int i = 0; i < 11; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         exec(t, vecs[i].instr, vecs[i].iw, vecs[i].dw, vecs[i].zero, o);
         check({t, ".cycles"},    o.cycles,        vecs[i].cycles);
         check({t, ".alu_op"},    32'(o.alu_op),   32'(vecs[i].alu_op));
         check({t, ".mem_read"},  o.mem_rd,        vecs[i].mem_rd);
         check({t, ".reg_write"}, o.reg_wr,        vecs[i].reg_wr);
         check({t, ".pc_write"},  o.pc_wr,         vecs[i].pc_wr);
         check({t, ".illegal"},   o.ill,           vecs[i].ill);
      end

      // Randomised instructions against the reference model (HALT excluded).
      for (int i = 0; i < 40; i++) begin
         int iw, dw;
         logic zero;
         do op = 4'($urandom_range(0, 15)); while (op == 4'd14);
         instr = {op, 12'($urandom)};
         iw    = $urandom_range(0, 2);
         dw    = $urandom_range(0, 3);
         zero  = 1'($urandom_range(0, 1));
         e = model(instr, iw, dw, zero);
         exec($sformatf("rnd%0d", i), instr, iw, dw, zero, o);
         cmp_all($sformatf("rnd%0d", i), o, e);
         check($sformatf("rnd%0d.ir", i), 32'(ir), 32'(instr));
      end

      // Reset in the middle of a stalled LW access.
      imem_valid = 1'b1;
      imem_rdata = 16'h9045;
      dmem_ready = 1'b0;
      guard = 0;
      while (state != 3'd3 && guard < 10) begin
         @(posedge clk);
         #1;
         imem_valid = 1'b0;
         guard++;
      end
      check("midmem.reached", 32'(state), 32'd3);
      check("midmem.mem_read_before", 32'(mem_read), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midmem.mem_read_after", 32'(mem_read), 32'd0);
      check("midmem.state",   32'(state),   32'd0);
      check("midmem.instret", 32'(instret), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = '0;
      exp_q.delete();

      // HALT: stays halted with imem_valid held high, until reset.
      exec("halt", 16'hE000, 0, 0, 1'b0, o);
      check("halt.cycles", o.cycles, 3);
      imem_valid = 1'b1;
      imem_rdata = 16'h0123;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      check("halt.halted",   32'(halted),   32'd1);
      check("halt.imem_req", 32'(imem_req), 32'd0);
      check("halt.state",    32'(state),    32'd5);
      check("halt.ir",       32'(ir),       32'hE000);
      check("halt.instret",  32'(instret),  32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("halt.rst_state",   32'(state),   32'd0);
      check("halt.rst_instret", 32'(instret), 32'd0);
      check("halt.rst_halted",  32'(halted),  32'd0);
      do_reset();

      // Counter wrap: fill to all-ones, then one more.
      for (int i = 0; i < (1 << CW) - 1; i++) begin
         run_instr(16'hD000, 0, 0, 1'b0, o, done);
         if (!done) check("wrap.retire_seen", 32'(done), 32'd1);
      end
      check("wrap.full", 32'(instret), 32'((1 << CW) - 1));
      run_instr(16'hD000, 0, 0, 1'b0, o, done);
      check("wrap.retire_last", 32'(done), 32'd1);
      check("wrap.zero", 32'(instret), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
